// File: rtl/nibseq_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package nibseq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice, purely combinational.
// Latency: 0 cycles (combinational).
// Backpressure: none; the sequencer owns all registers.
// Ports: a/b nibble operands, ci carry in -> s nibble sum, co carry out.
module cla4_slice
    import nibseq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    logic [NIB_W-1:0] p;
    logic [NIB_W-1:0] g;
    logic [NIB_W:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Flattened lookahead equations so every carry is two levels deep.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c[NIB_W-1:0];
    assign co = c[NIB_W];

endmodule

// File: rtl/nibble_add_seq.sv
// Multi-cycle WIDTH-bit add/sub using one 4-bit CLA slice, LSB nibble first.
// Latency: start accepted at edge k -> done high during [k+N, k+N+1); N = WIDTH/4.
// Backpressure: ready high only in IDLE; start is ignored while busy, no queuing.
// Ports: clk, rst_n (async active-low); start/sub/a/b request; ready, done,
// result, cout (1 = no borrow for sub), ovf (signed overflow) all registered.
// Optional: define NIBSEQ_ABORT_EN to add the abort input (abort in RUN -> IDLE).
module nibble_add_seq
    import nibseq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
`ifdef NIBSEQ_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam int N     = WIDTH / NIB_W;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    state_t           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             ovf_q;

    logic [NIB_W-1:0] slice_s;
    logic             slice_co;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] opa_d;
    logic [WIDTH-1:0] opb_d;
    logic             ovf_d;
    logic             abort_req;

    cla4_slice u_slice (
        .a  (opa_q[NIB_W-1:0]),
        .b  (opb_q[NIB_W-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // Sum nibbles enter at the top, so after N steps the LSB nibble has
    // shifted all the way down to bit 0.
    assign acc_d = {slice_s, acc_q[WIDTH-1:NIB_W]};
    assign opa_d = {{NIB_W{1'b0}}, opa_q[WIDTH-1:NIB_W]};
    assign opb_d = {{NIB_W{1'b0}}, opb_q[WIDTH-1:NIB_W]};

    // On the final step the operand low nibbles are the original top nibbles,
    // so bit 3 is the operand sign (opb already inverted for subtraction).
    assign ovf_d = (opa_q[NIB_W-1] == opb_q[NIB_W-1]) &&
                   (slice_s[NIB_W-1] != opa_q[NIB_W-1]);

`ifdef NIBSEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= sub ? ~b : b;
                        carry_q <= sub;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Abort takes priority, including over the final step.
                    if (abort_req) begin
                        idx_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        acc_q   <= acc_d;
                        opa_q   <= opa_d;
                        opb_q   <= opb_d;
                        carry_q <= slice_co;
                        if (idx_q == IDX_LAST) begin
                            result_q <= acc_d;
                            cout_q   <= slice_co;
                            ovf_q    <= ovf_d;
                            idx_q    <= '0;
                            state_q  <= DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed self-checking bench for nibble_add_seq at WIDTH=32.
// Latency: done expected 8 edges after the start edge.
// Backpressure: exercises start held high while busy.
module tb_nibble_add_seq;

    localparam int WIDTH = 32;
    localparam int N     = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
`ifdef NIBSEQ_ABORT_EN
    logic             abort;
`endif

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] last_res;
    logic             last_cout;
    logic             last_ovf;

    nibble_add_seq #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
`ifdef NIBSEQ_ABORT_EN
        ,
        .abort  (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and check latency, hold behaviour and final values.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic ts, input logic [31:0] er, input logic ec, input logic eo);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_ready_low"}, 32'(ready), 32'd0);
        for (int i = 1; i < N; i++) begin
            tick();
            chk({tag, "_no_early_done"}, 32'(done), 32'd0);
            if (i == 4) chk({tag, "_result_held"}, result, last_res);
        end
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_result"}, result, er);
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        tick();
        chk({tag, "_done_single"}, 32'(done), 32'd0);
        chk({tag, "_ready_back"}, 32'(ready), 32'd1);
        last_res = er; last_cout = ec; last_ovf = eo;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
`ifdef NIBSEQ_ABORT_EN
        abort = 1'b0;
`endif
        last_res = '0; last_cout = 1'b0; last_ovf = 1'b0;

        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op("add_wrap", 32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run_op("add_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_op("sub_neg",  32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",  32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        run_op("add_mix",  32'h12345678, 32'h0FEDCBA9, 1'b0, 32'h22222221, 1'b0, 1'b0);

        // start held high; operands change during RUN and must not leak in.
        a = 32'd1; b = 32'd2; sub = 1'b0; start = 1'b1;
        tick();
        chk("held_accept", 32'(ready), 32'd0);
        a = 32'd100; b = 32'd200;
        for (int e = 1; e <= 18; e++) begin
            tick();
            chk("held_done_timing", 32'(done), 32'((e == 8) || (e == 18)));
            chk("held_ready_timing", 32'(ready), 32'(e == 9));
            if (e == 8)  chk("held_result1", result, 32'd3);
            if (e == 18) chk("held_result2", result, 32'h0000012C);
        end
        start = 1'b0;
        tick();
        chk("held_idle", 32'(ready), 32'd1);
        last_res = 32'h0000012C; last_cout = 1'b0; last_ovf = 1'b0;

        // Reset in the middle of RUN.
        a = 32'hFFFFFFFF; b = 32'h00000001; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", result, 32'h0);
        chk("midrst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("midrst_no_stale_done", 32'(done), 32'd0);
        end
        last_res = '0; last_cout = 1'b0; last_ovf = 1'b0;

        run_op("post_rst", 32'h12345678, 32'h0FEDCBA9, 1'b0, 32'h22222221, 1'b0, 1'b0);

`ifdef NIBSEQ_ABORT_EN
        // Abort at RUN step 4.
        a = 32'h00000003; b = 32'h00000004; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort4_ready", 32'(ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort4_no_done", 32'(done), 32'd0);
        end
        chk("abort4_result_kept", result, last_res);

        // Abort coinciding with the final step.
        a = 32'h00000003; b = 32'h00000004; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < N - 1; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abortN_ready", 32'(ready), 32'd1);
        chk("abortN_no_done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abortN_no_late_done", 32'(done), 32'd0);
        end
        chk("abortN_result_kept", result, last_res);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
